fpga_status_led_ctrl: RTL and testbench

Parametrised board-status indicator for the FPGA top level. It generalises the single clock-activity blink counter into N independently moded LED channels, adds event pulse-stretching, and adds a sticky end-of-program pass/fail display. It sits beside `x_heep_system` in the FPGA wrapper, is clocked by the clock-wizard output, and drives board LEDs only.

---
 rtl/fpga_status_led_ctrl_if.sv | 28 ++
 rtl/fpga_status_led_ctrl.sv | 91 +++++++++
 tb/tb_fpga_status_led_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpga_status_led_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fpga_status_led_ctrl_if
// Description : Mode/event/exit inputs and LED outputs of the status LED block.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpga_status_led_ctrl_if #(
    parameter int NUM_LEDS = 4
);
    logic [2*NUM_LEDS-1:0] mode_i;
    logic [NUM_LEDS-1:0]   event_i;
    logic                  exit_valid_i;
    logic [31:0]           exit_value_i;
    logic [NUM_LEDS-1:0]   led_o;
    logic                  heartbeat_o;
    logic                  exit_done_o;

    modport master (
        output mode_i, event_i, exit_valid_i, exit_value_i,
        input  led_o, heartbeat_o, exit_done_o
    );

    modport slave (
        input  mode_i, event_i, exit_valid_i, exit_value_i,
        output led_o, heartbeat_o, exit_done_o
    );
endinterface
`default_nettype wire

// File: rtl/fpga_status_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fpga_status_led_ctrl
// Description : N-channel board LED driver with heartbeat, event stretching and
//               a sticky program pass/fail display.
// Revision    : 1.0 - initial release
// ============================================================================
module fpga_status_led_ctrl #(
    parameter int NUM_LEDS      = 4,
    parameter int PRESCALE_W    = 27,
    parameter int STRETCH_TICKS = 3
) (
    input wire                     clk_gen,
    input wire                     rst_n,
    fpga_status_led_ctrl_if.slave  bus
);
    localparam int c_SC_W = $clog2(STRETCH_TICKS + 1);

    localparam logic [1:0] c_MODE_OFF     = 2'b00;
    localparam logic [1:0] c_MODE_ON      = 2'b01;
    localparam logic [1:0] c_MODE_BLINK   = 2'b10;
    localparam logic [1:0] c_MODE_STRETCH = 2'b11;

    localparam logic [c_SC_W-1:0] c_SC_LOAD = c_SC_W'(STRETCH_TICKS);

    logic [PRESCALE_W-1:0] r_cnt;
    logic [2*NUM_LEDS-1:0] r_mode;
    logic                  r_exit_done;
    logic                  r_exit_fail;
    logic                  w_tick;
    logic                  w_hb;
    logic                  w_fast;
    logic [NUM_LEDS-1:0]   w_led_norm;

    assign w_tick = &r_cnt;
    assign w_hb   = r_cnt[PRESCALE_W-1];
    assign w_fast = r_cnt[PRESCALE_W-3];

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_mode      <= {NUM_LEDS{c_MODE_OFF}};
            r_exit_done <= 1'b0;
            r_exit_fail <= 1'b0;
        end else begin
            r_cnt  <= r_cnt + PRESCALE_W'(1);
            r_mode <= bus.mode_i;
            // Only the first exit strobe counts; the result is held until reset.
            if (bus.exit_valid_i && !r_exit_done) begin
                r_exit_done <= 1'b1;
                r_exit_fail <= (bus.exit_value_i != 32'd0);
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
            logic [c_SC_W-1:0] r_sc;
            logic [1:0]        w_mode_in;
            logic [1:0]        w_mode_q;

            assign w_mode_in = bus.mode_i[2*i +: 2];
            assign w_mode_q  = r_mode[2*i +: 2];

            // Load follows the live mode input so a stretch event is seen at t+1,
            // and a reload beats a coincident prescaler tick.
            always_ff @(posedge clk_gen or negedge rst_n) begin
                if (!rst_n) begin
                    r_sc <= '0;
                end else if (w_mode_in != c_MODE_STRETCH) begin
                    r_sc <= '0;
                end else if (bus.event_i[i]) begin
                    r_sc <= c_SC_LOAD;
                end else if (w_tick && (r_sc != '0)) begin
                    r_sc <= r_sc - c_SC_W'(1);
                end
            end

            assign w_led_norm[i] = (w_mode_q == c_MODE_ON)
                                 | ((w_mode_q == c_MODE_BLINK)   & w_hb)
                                 | ((w_mode_q == c_MODE_STRETCH) & (r_sc != '0));
        end
    endgenerate

    assign bus.heartbeat_o = w_hb;
    assign bus.exit_done_o = r_exit_done;
    assign bus.led_o       = !r_exit_done ? w_led_norm
                           : (r_exit_fail ? {NUM_LEDS{w_fast}} : {NUM_LEDS{1'b1}});

endmodule
`default_nettype wire

// File: tb/tb_fpga_status_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpga_status_led_ctrl
// Description : Randomised self-checking bench against a cycle-indexed model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpga_status_led_ctrl;
    localparam int N  = 4;
    localparam int W  = 4;
    localparam int ST = 3;
    localparam int P  = 1 << W;

    logic clk_gen = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_gen = ~clk_gen;

    fpga_status_led_ctrl_if #(.NUM_LEDS(N)) bus ();

    fpga_status_led_ctrl #(
        .NUM_LEDS(N), .PRESCALE_W(W), .STRETCH_TICKS(ST)
    ) dut (
        .clk_gen(clk_gen),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: k = clock edges since reset release (prescaler = k mod P).
    // s_end[i] = last cycle index in which a stretched LED is lit.
    int         k;
    logic [7:0] m_mode;
    int         s_end [N];
    bit         m_done;
    bit         m_fail;

    function automatic int stretch_end_from(int t);
        int first;
        first = t + (P - 1 - (t % P));
        if (first == t) first += P;
        return first + P * (ST - 1);
    endfunction

    function automatic logic exp_hb();
        return (k % P) >= (P / 2);
    endfunction

    function automatic logic [N-1:0] exp_led();
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (m_done)
                r[i] = m_fail ? ((((k % P) / 2) % 2) == 1) : 1'b1;
            else
                case (m_mode[2*i +: 2])
                    2'd0: r[i] = 1'b0;
                    2'd1: r[i] = 1'b1;
                    2'd2: r[i] = exp_hb();
                    default: r[i] = (k <= s_end[i]);
                endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        k = 0; m_mode = '0; m_done = 0; m_fail = 0;
        for (int i = 0; i < N; i++) s_end[i] = -1;
    endtask

    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            if (bus.event_i[i] && bus.mode_i[2*i +: 2] == 2'd3) s_end[i] = stretch_end_from(k);
            else if (bus.mode_i[2*i +: 2] != 2'd3)              s_end[i] = -1;
        end
        m_mode = bus.mode_i;
        if (!m_done && bus.exit_valid_i) begin
            m_done = 1;
            m_fail = (bus.exit_value_i != 32'd0);
        end
        k++;
    endtask

    task automatic cyc();
        @(posedge clk_gen);
        model_edge();
        @(negedge clk_gen);
    endtask

    task automatic apply_reset(string tag);
        @(negedge clk_gen);
        rst_n = 1'b0;
        #1;
        n_total++;
        if (bus.led_o !== 4'b0000 || bus.exit_done_o !== 1'b0 || bus.heartbeat_o !== 1'b0)
            $display("FAIL %s_in_reset led=%b done=%b hb=%b, want 0000/0/0", tag,
                     bus.led_o, bus.exit_done_o, bus.heartbeat_o);
        else n_pass++;
        model_reset();
        repeat (2) @(posedge clk_gen);
        @(negedge clk_gen);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int first_rise, highs;
        logic prev;
        bus.mode_i = '0; bus.event_i = '0; bus.exit_valid_i = 1'b0; bus.exit_value_i = '0;
        apply_reset("reset");
        first_rise = -1; highs = 0; prev = bus.heartbeat_o;
        for (int c = 0; c < 40; c++) begin
            cyc();
            n_total++;
            if (bus.led_o !== exp_led() || bus.heartbeat_o !== exp_hb())
                $display("FAIL reset_idle k=%0d led=%b hb=%b, want %b/%b", k, bus.led_o,
                         bus.heartbeat_o, exp_led(), exp_hb());
            else n_pass++;
            if (bus.heartbeat_o && !prev && first_rise < 0) first_rise = k;
            if (k >= 16 && k < 32 && bus.heartbeat_o) highs++;
            prev = bus.heartbeat_o;
        end
        n_total++;
        if (first_rise !== 8) $display("FAIL hb_first_rise got=%0d want=8", first_rise);
        else n_pass++;
        n_total++;
        if (highs !== 8) $display("FAIL hb_duty got=%0d want=8", highs);
        else n_pass++;
        n_total++;
        if (bus.exit_done_o !== 1'b0) $display("FAIL reset_exit_done got=%b want=0", bus.exit_done_o);
        else n_pass++;
    endtask

    task automatic test_modes();
        bus.mode_i = 8'b00_00_10_01;
        cyc();
        n_total++;
        if (bus.led_o[0] !== 1'b1) $display("FAIL mode_on_latency got=%b want=1", bus.led_o[0]);
        else n_pass++;
        for (int c = 0; c < 32; c++) begin
            cyc();
            n_total++;
            if (bus.led_o !== exp_led() || bus.led_o[1] !== exp_hb() || bus.led_o[3:2] !== 2'b00)
                $display("FAIL modes k=%0d led=%b, want %b", k, bus.led_o, exp_led());
            else n_pass++;
        end
    endtask

    task automatic stretch_run(string tag, int align, int second_gap, int cycles, int want_lit);
        int lit;
        bus.mode_i = 8'b00_11_00_00;
        bus.event_i = '0;
        for (int c = 0; c < 2 * P && (k % P) != align; c++) cyc();
        bus.event_i[2] = 1'b1;
        cyc();
        bus.event_i[2] = 1'b0;
        lit = 0;
        for (int c = 0; c < cycles; c++) begin
            if (bus.led_o[2]) lit++;
            n_total++;
            if (bus.led_o !== exp_led())
                $display("FAIL %s k=%0d led=%b, want %b", tag, k, bus.led_o, exp_led());
            else n_pass++;
            bus.event_i[2] = (second_gap > 0 && c == second_gap - 1);
            cyc();
            bus.event_i[2] = 1'b0;
        end
        n_total++;
        if (lit !== want_lit) $display("FAIL %s_lit_cycles got=%0d want=%0d", tag, lit, want_lit);
        else n_pass++;
    endtask

    task automatic test_stretch();
        stretch_run("stretch_single", 0, 0, 60, 47);
        stretch_run("stretch_retrig", 0, 20, 80, 63);
        stretch_run("stretch_on_tick", P - 1, 0, 60, 48);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 15) == 0) bus.mode_i = 8'($urandom);
            bus.event_i = 4'($urandom) & 4'($urandom) & 4'($urandom);
            cyc();
            n_total++;
            if (bus.led_o !== exp_led() || bus.heartbeat_o !== exp_hb() || bus.exit_done_o !== 1'b0)
                $display("FAIL random k=%0d led=%b hb=%b, want %b/%b", k, bus.led_o,
                         bus.heartbeat_o, exp_led(), exp_hb());
            else n_pass++;
        end
        bus.event_i = '0;
    endtask

    task automatic test_exit_pass();
        bus.exit_valid_i = 1'b1; bus.exit_value_i = 32'd0;
        cyc();
        bus.exit_valid_i = 1'b0;
        n_total++;
        if (bus.exit_done_o !== 1'b1 || bus.led_o !== 4'b1111)
            $display("FAIL exit_pass done=%b led=%b, want 1/1111", bus.exit_done_o, bus.led_o);
        else n_pass++;
        repeat (3) cyc();
        bus.exit_valid_i = 1'b1; bus.exit_value_i = 32'd5;
        for (int c = 0; c < 20; c++) begin
            bus.mode_i = 8'($urandom);
            bus.event_i = 4'($urandom);
            cyc();
            bus.exit_valid_i = 1'b0;
            n_total++;
            if (bus.led_o !== exp_led() || bus.led_o !== 4'b1111 || bus.exit_done_o !== 1'b1)
                $display("FAIL exit_pass_hold k=%0d led=%b done=%b, want 1111/1", k,
                         bus.led_o, bus.exit_done_o);
            else n_pass++;
        end
        bus.event_i = '0;
    endtask

    task automatic test_exit_fail();
        apply_reset("exit_fail");
        bus.exit_valid_i = 1'b1; bus.exit_value_i = 32'h8000_0000;
        cyc();
        for (int c = 0; c < 20; c++) begin
            if (c == 2) bus.exit_valid_i = 1'b0;
            n_total++;
            if (bus.led_o !== exp_led() || bus.exit_done_o !== 1'b1)
                $display("FAIL exit_fail k=%0d led=%b done=%b, want %b/1", k, bus.led_o,
                         bus.exit_done_o, exp_led());
            else n_pass++;
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        bus.exit_valid_i = 1'b0;
        apply_reset("pre_mid");
        bus.mode_i = 8'b00_11_00_01;
        cyc();
        bus.event_i[2] = 1'b1;
        cyc();
        bus.event_i[2] = 1'b0;
        repeat (5) cyc();
        apply_reset("mid_stretch");
        for (int c = 0; c < 20; c++) begin
            cyc();
            n_total++;
            if (bus.led_o !== exp_led())
                $display("FAIL after_stretch_reset k=%0d led=%b, want %b", k, bus.led_o, exp_led());
            else n_pass++;
        end
        bus.exit_valid_i = 1'b1; bus.exit_value_i = 32'd7;
        cyc();
        bus.exit_valid_i = 1'b0;
        repeat (3) cyc();
        apply_reset("mid_override");
        for (int c = 0; c < 20; c++) begin
            cyc();
            n_total++;
            if (bus.led_o !== exp_led() || bus.exit_done_o !== 1'b0)
                $display("FAIL after_override_reset k=%0d led=%b done=%b, want %b/0", k,
                         bus.led_o, bus.exit_done_o, exp_led());
            else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_modes();
        test_stretch();
        test_random();
        test_exit_pass();
        test_exit_fail();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
